fetch_decode_buffer: RTL and testbench

IF/ID pipeline register between the fetch stage and the decoder. It takes the 16-bit word stream from fetch and joins two-word instructions (opcode word plus 16-bit immediate word) into one decode packet. It presents one registered packet per instruction to decode, holds it under hazard stall, and discards in-flight words on jump, direct jump or interrupt.

---
 rtl/pipeline_pkg.sv | 43 ++++
 rtl/fetch_decode_buffer.sv | 140 ++++++++++++++
 tb/tb_fetch_decode_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the IF/ID and ID/EX pipeline registers.
//   fd_state_e     : fetch/decode joiner state (EXPECT_OP, WAIT_IMM)
//   NEEDS_IMM      : opcode prefix (word[15:13]) of two-word instructions
//   NOP_INSTR      : default instruction word presented during bubbles
//   decode_pkt_t   : decode packet {valid, instr, imm, pc}
//   needs_imm()    : true when an opcode word is followed by an immediate
//   bubble_pkt()   : builds an invalid packet carrying the given NOP word
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [0:0] {
        EXPECT_OP = 1'b0,
        WAIT_IMM  = 1'b1
    } fd_state_e;

    localparam logic [2:0]  NEEDS_IMM = 3'b110;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] pc;
    } decode_pkt_t;

    // Two-word instructions are identified purely by their top three bits.
    function automatic logic needs_imm(input logic [15:0] word);
        return (word[15:13] == NEEDS_IMM);
    endfunction

    // A bubble carries no address and no immediate, only the NOP word.
    function automatic decode_pkt_t bubble_pkt(input logic [15:0] nop_word);
        decode_pkt_t p;
        p.valid = 1'b0;
        p.instr = nop_word;
        p.imm   = 16'h0000;
        p.pc    = 16'h0000;
        return p;
    endfunction

endpackage

// File: rtl/fetch_decode_buffer.sv
// -----------------------------------------------------------------------------
// fetch_decode_buffer
// IF/ID pipeline register. Joins an opcode word and its 16-bit immediate into a
// single registered decode packet, holds the packet while the hazard unit
// stalls, and drops any partially assembled instruction on a flush.
//
// Parameters
//   NOP_WORD         instruction word presented while decode_valid = 0
// Ports
//   clk              pipeline clock (rising edge)
//   rst              asynchronous active-high reset
//   instruction_buf  16-bit word from fetch
//   fetch_valid      instruction_buf is meaningful this cycle
//   fetch_pc         address of instruction_buf
//   stall            hold the current decode packet
//   jump_occured     conditional jump taken (flush)
//   direct_jump      unconditional jump (flush)
//   interrupt        interrupt entry (flush)
//   decode_valid     packet is a real instruction
//   decode_instr     opcode word
//   decode_imm       immediate word (0 for one-word instructions)
//   decode_pc        address of the opcode word
//   fetch_hold       fetch must not advance its PC this cycle (combinational)
// -----------------------------------------------------------------------------
module fetch_decode_buffer
    import pipeline_pkg::*;
#(
    parameter logic [15:0] NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction_buf,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_pc,
    input  logic        stall,
    input  logic        jump_occured,
    input  logic        direct_jump,
    input  logic        interrupt,
    output logic        decode_valid,
    output logic [15:0] decode_instr,
    output logic [15:0] decode_imm,
    output logic [15:0] decode_pc,
    output logic        fetch_hold
);

    fd_state_e   state_q,   state_d;
    logic [15:0] op_hold_q, op_hold_d;
    logic [15:0] pc_hold_q, pc_hold_d;
    decode_pkt_t pkt_q,     pkt_d;

    logic        flush_s;

    // Flush sources and the fetch back-pressure output.
    always_comb begin
        flush_s    = jump_occured | direct_jump | interrupt;
        // A flush redirects fetch anyway, so it must never be held back.
        fetch_hold = stall & ~flush_s;
    end

    // Next-state and next-packet logic; priority is flush, then stall, then accept.
    always_comb begin
        state_d   = state_q;
        op_hold_d = op_hold_q;
        pc_hold_d = pc_hold_q;
        pkt_d     = pkt_q;

        if (flush_s) begin
            // Any half-assembled two-word instruction is discarded.
            state_d   = EXPECT_OP;
            op_hold_d = 16'h0000;
            pc_hold_d = 16'h0000;
            pkt_d     = bubble_pkt(NOP_WORD);
        end else if (stall) begin
            // Everything freezes, including a pending opcode in WAIT_IMM.
            state_d   = state_q;
            op_hold_d = op_hold_q;
            pc_hold_d = pc_hold_q;
            pkt_d     = pkt_q;
        end else if (fetch_valid) begin
            case (state_q)
                EXPECT_OP: begin
                    if (needs_imm(instruction_buf)) begin
                        // Park the opcode; decode sees a bubble this cycle.
                        op_hold_d = instruction_buf;
                        pc_hold_d = fetch_pc;
                        pkt_d     = bubble_pkt(NOP_WORD);
                        state_d   = WAIT_IMM;
                    end else begin
                        pkt_d.valid = 1'b1;
                        pkt_d.instr = instruction_buf;
                        pkt_d.imm   = 16'h0000;
                        pkt_d.pc    = fetch_pc;
                        state_d     = EXPECT_OP;
                    end
                end
                WAIT_IMM: begin
                    // The accepted word is the immediate of the parked opcode.
                    pkt_d.valid = 1'b1;
                    pkt_d.instr = op_hold_q;
                    pkt_d.imm   = instruction_buf;
                    pkt_d.pc    = pc_hold_q;
                    state_d     = EXPECT_OP;
                end
                default: begin
                    state_d   = EXPECT_OP;
                    op_hold_d = 16'h0000;
                    pc_hold_d = 16'h0000;
                    pkt_d     = bubble_pkt(NOP_WORD);
                end
            endcase
        end else begin
            // Fetch had nothing this cycle: emit a bubble, keep the FSM where it is.
            pkt_d = bubble_pkt(NOP_WORD);
        end
    end

    // State, hold and packet registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EXPECT_OP;
            op_hold_q <= 16'h0000;
            pc_hold_q <= 16'h0000;
            pkt_q     <= bubble_pkt(NOP_WORD);
        end else begin
            state_q   <= state_d;
            op_hold_q <= op_hold_d;
            pc_hold_q <= pc_hold_d;
            pkt_q     <= pkt_d;
        end
    end

    // Packet fields drive the decode stage straight from flops.
    always_comb begin
        decode_valid = pkt_q.valid;
        decode_instr = pkt_q.instr;
        decode_imm   = pkt_q.imm;
        decode_pc    = pkt_q.pc;
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_buffer
// Directed stimulus pushes hand-computed expectations into a queue; a separate
// monitor pops one entry 1 ns after every rising clock edge (and after an
// asynchronous reset assertion) and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instruction_buf = 16'h0000;
    logic        fetch_valid = 1'b0;
    logic [15:0] fetch_pc = 16'h0000;
    logic        stall = 1'b0;
    logic        jump_occured = 1'b0;
    logic        direct_jump = 1'b0;
    logic        interrupt = 1'b0;
    logic        decode_valid;
    logic [15:0] decode_instr;
    logic [15:0] decode_imm;
    logic [15:0] decode_pc;
    logic        fetch_hold;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        v;
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] pc;
        logic        hold;
    } exp_t;

    exp_t exp_q[$];

    fetch_decode_buffer #(.NOP_WORD(16'h0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .instruction_buf (instruction_buf),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .stall           (stall),
        .jump_occured    (jump_occured),
        .direct_jump     (direct_jump),
        .interrupt       (interrupt),
        .decode_valid    (decode_valid),
        .decode_instr    (decode_instr),
        .decode_imm      (decode_imm),
        .decode_pc       (decode_pc),
        .fetch_hold      (fetch_hold)
    );

    always #5 clk = ~clk;

    // Monitor: compares DUT outputs against the oldest queued expectation.
    always @(posedge clk or posedge rst) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (decode_valid !== e.v || decode_instr !== e.instr ||
                decode_imm !== e.imm || decode_pc !== e.pc || fetch_hold !== e.hold) begin
                errors++;
                $display("FAIL %s: got v=%0b instr=%h imm=%h pc=%h hold=%0b, expected v=%0b instr=%h imm=%h pc=%h hold=%0b",
                         e.name, decode_valid, decode_instr, decode_imm, decode_pc, fetch_hold,
                         e.v, e.instr, e.imm, e.pc, e.hold);
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic v, input logic [15:0] ins,
                                input logic [15:0] imm, input logic [15:0] pc, input logic h);
        exp_t e;
        e.name = nm; e.v = v; e.instr = ins; e.imm = imm; e.pc = pc; e.hold = h;
        return e;
    endfunction

    // One cycle of stimulus, applied at the falling edge, plus the expected
    // outputs after the following rising edge. With r=1 the reset is asserted
    // mid-cycle and the outputs are also expected to clear immediately.
    task automatic step(input string nm, input logic r, input logic fv,
                        input logic [15:0] w, input logic [15:0] pc,
                        input logic st, input logic j, input logic d, input logic i,
                        input logic ev, input logic [15:0] ei,
                        input logic [15:0] eimm, input logic [15:0] epc, input logic eh);
        @(negedge clk);
        fetch_valid     = fv;
        instruction_buf = w;
        fetch_pc        = pc;
        stall           = st;
        jump_occured    = j;
        direct_jump     = d;
        interrupt       = i;
        if (r) begin
            exp_q.push_back(mk({nm, "_async"}, ev, ei, eimm, epc, eh));
            exp_q.push_back(mk(nm, ev, ei, eimm, epc, eh));
            rst = 1'b1;
        end else begin
            exp_q.push_back(mk(nm, ev, ei, eimm, epc, eh));
            rst = 1'b0;
        end
    endtask

    initial begin
        // Initial reset.
        step("reset0",      1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        // Opcode C123 parks in WAIT_IMM, then reset hits mid-instruction.
        step("op_c123",     1'b0, 1'b1, 16'hC123, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("reset_mid",   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("post_reset",  1'b0, 1'b1, 16'h0042, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 16'h0005, 1'b0);
        // One-word stream.
        step("one_w0",      1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0000, 1'b0);
        step("one_w1",      1'b0, 1'b1, 16'h2022, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2022, 16'h0000, 16'h0001, 1'b0);
        // Two-word instruction.
        step("two_op",      1'b0, 1'b1, 16'hC401, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("two_imm",     1'b0, 1'b1, 16'hBEEF, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC401, 16'hBEEF, 16'h0008, 1'b0);
        // Stall holds packet for three cycles.
        step("pre_stall",   1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0000, 1'b0);
        for (int k = 0; k < 3; k++)
            step("stall_hold", 1'b0, 1'b1, 16'h0055, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0000, 1'b1);
        step("unstall",     1'b0, 1'b1, 16'h0055, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055, 16'h0000, 16'h0001, 1'b0);
        // Jump while in WAIT_IMM discards the opcode.
        step("jmp_op",      1'b0, 1'b1, 16'hC401, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("jmp_flush",   1'b0, 1'b1, 16'hBEEF, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("jmp_next",    1'b0, 1'b1, 16'h0033, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0033, 16'h0000, 16'h000A, 1'b0);
        // Stall together with direct_jump / interrupt: flush wins.
        step("dj_pre",      1'b0, 1'b1, 16'h0044, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0044, 16'h0000, 16'h0002, 1'b0);
        step("stall_dj",    1'b0, 1'b1, 16'h0077, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("irq_pre",     1'b0, 1'b1, 16'h0066, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0066, 16'h0000, 16'h0003, 1'b0);
        step("stall_irq",   1'b0, 1'b1, 16'h0077, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        // No valid fetch word: bubble.
        step("no_fetch",    1'b0, 1'b0, 16'h1111, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        // Stall while in WAIT_IMM keeps the pending opcode.
        step("wi_op",       1'b0, 1'b1, 16'hC500, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step("wi_stall0",   1'b0, 1'b1, 16'h1234, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        step("wi_stall1",   1'b0, 1'b1, 16'h1234, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        step("wi_imm",      1'b0, 1'b1, 16'h1234, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC500, 16'h1234, 16'h0010, 1'b0);
        // Fetch valid without immediate after a two-word packet.
        step("after_two",   1'b0, 1'b1, 16'hE001, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hE001, 16'h0000, 16'h0012, 1'b0);

        // Drain: bounded wait for the monitor to consume everything.
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
